memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_memory_stage.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: load/store pipeline stage between execute and writeback.
// Optional MISALIGN_TRAP_EN: misaligned accesses raise dataM.exc instead of being aligned down.
package memory_stage_pkg;

   typedef struct packed {
      logic [3:0] op;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
   } ctl_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instruction;
      logic [63:0] result;
      logic [63:0] memdata;
      ctl_t        ctl;
      logic [4:0]  dst;
   } execute_data_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instruction;
      logic [63:0] result;
      logic        regwrite;
      logic [4:0]  dst;
`ifdef MISALIGN_TRAP_EN
      logic        exc;
`endif
   } memory_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// Handshakes: a transfer happens on a rising edge where valid && ready; the producer
// holds valid and its payload stable until then, and ready never depends on the payload.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic          clk,
   input  logic          resetn,
   input  execute_data_t dataE,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          dreq_valid,
   output logic [63:0]   dreq_addr,
   output logic          dreq_write,
   output logic [2:0]    dreq_size,
   output logic [7:0]    dreq_strobe,
   output logic [63:0]   dreq_data,
   input  logic          dresp_data_ok,
   input  logic [63:0]   dresp_data,
   output memory_data_t  dataM,
   output logic          out_valid,
   input  logic          out_ready,
   output state_t        dbg_state
);

   state_t      state;
   state_t      state_nxt;
   logic        in_fire;
   logic        bus_done;
   logic        is_mem;
   logic        trap_e;
   logic        go_direct;
   logic        go_bus;
   logic [2:0]  funct3;
   logic [1:0]  size_e;
   logic [2:0]  align_mask;
   logic [7:0]  size_mask;
   logic [63:0] addr_e;

   logic [63:0] req_addr;
   logic        req_write;
   logic [2:0]  req_size;
   logic [7:0]  req_strobe;
   logic [63:0] req_data;
   logic [2:0]  req_funct3;
   logic [63:0] req_pc;
   logic [31:0] req_instr;
   logic        req_regwrite;
   logic [4:0]  req_dst;

   logic [63:0] ld_shift;
   logic [63:0] ld_ext;
   logic        unused_bits;

   assign unused_bits = ^dataE.ctl.op;

   // ---------------- decode of the incoming instruction ----------------
   assign funct3 = dataE.instruction[14:12];
   assign size_e = funct3[1:0];
   assign is_mem = dataE.ctl.memread || dataE.ctl.memwrite;

   always_comb begin
      align_mask = 3'b000;
      size_mask  = 8'h01;
      case (size_e)
         2'd0: begin align_mask = 3'b000; size_mask = 8'h01; end
         2'd1: begin align_mask = 3'b001; size_mask = 8'h03; end
         2'd2: begin align_mask = 3'b011; size_mask = 8'h0F; end
         default: begin align_mask = 3'b111; size_mask = 8'hFF; end
      endcase
   end

   // Without the trap the low address bits are simply cleared to the access size.
   assign addr_e = {dataE.result[63:3], dataE.result[2:0] & ~align_mask};

`ifdef MISALIGN_TRAP_EN
   assign trap_e = is_mem && (|(dataE.result[2:0] & align_mask));
`else
   assign trap_e = 1'b0;
`endif

   assign in_fire   = in_valid && in_ready;
   assign go_direct = in_fire && (!is_mem || trap_e);
   assign go_bus    = in_fire && is_mem && !trap_e;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      dreq_valid = 1'b0;
      bus_done   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = resetn && (!out_valid || out_ready);
            if (in_valid && in_ready && is_mem && !trap_e) state_nxt = BUS;
         end
         BUS: begin
            dreq_valid = 1'b1;
            if (dresp_data_ok) begin
               bus_done  = 1'b1;
               state_nxt = out_ready ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dbg_state = state;

   // ---------------- request latch; held for the whole BUS phase ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_addr     <= '0;
         req_write    <= 1'b0;
         req_size     <= '0;
         req_strobe   <= '0;
         req_data     <= '0;
         req_funct3   <= '0;
         req_pc       <= '0;
         req_instr    <= '0;
         req_regwrite <= 1'b0;
         req_dst      <= '0;
      end else if (go_bus) begin
         req_addr     <= addr_e;
         req_write    <= dataE.ctl.memwrite;
         req_size     <= {1'b0, size_e};
         req_strobe   <= dataE.ctl.memwrite ? (size_mask << addr_e[2:0]) : 8'h00;
         req_data     <= dataE.ctl.memwrite ? (dataE.memdata << {addr_e[2:0], 3'b000}) : 64'h0;
         req_funct3   <= funct3;
         req_pc       <= dataE.pc;
         req_instr    <= dataE.instruction;
         req_regwrite <= dataE.ctl.regwrite && !dataE.ctl.memwrite;
         req_dst      <= dataE.dst;
      end
   end

   assign dreq_addr   = req_addr;
   assign dreq_write  = req_write;
   assign dreq_size   = req_size;
   assign dreq_strobe = req_strobe;
   assign dreq_data   = req_data;

   // ---------------- load return alignment and extension ----------------
   assign ld_shift = dresp_data >> {req_addr[2:0], 3'b000};

   always_comb begin
      ld_ext = ld_shift;
      case (req_funct3)
         3'b000:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
         3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
         3'b100:  ld_ext = {56'h0, ld_shift[7:0]};
         3'b101:  ld_ext = {48'h0, ld_shift[15:0]};
         3'b110:  ld_ext = {32'h0, ld_shift[31:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   // ---------------- writeback register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dataM     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_ready) out_valid <= 1'b0;
         if (go_direct) begin
            dataM.pc          <= dataE.pc;
            dataM.instruction <= dataE.instruction;
            dataM.result      <= dataE.result;
            dataM.regwrite    <= dataE.ctl.regwrite && !trap_e;
            dataM.dst         <= dataE.dst;
`ifdef MISALIGN_TRAP_EN
            dataM.exc         <= trap_e;
`endif
            out_valid         <= 1'b1;
         end else if (bus_done) begin
            dataM.pc          <= req_pc;
            dataM.instruction <= req_instr;
            dataM.result      <= req_write ? req_addr : ld_ext;
            dataM.regwrite    <= req_regwrite;
            dataM.dst         <= req_dst;
`ifdef MISALIGN_TRAP_EN
            dataM.exc         <= 1'b0;
`endif
            out_valid         <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized mix,
// with a scoreboard queue of expected writeback packets {exc, regwrite, dst, result}.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int W = 71;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   execute_data_t dataE;
   logic          in_valid;
   logic          in_ready;
   logic          dreq_valid;
   logic [63:0]   dreq_addr;
   logic          dreq_write;
   logic [2:0]    dreq_size;
   logic [7:0]    dreq_strobe;
   logic [63:0]   dreq_data;
   logic          dresp_data_ok;
   logic [63:0]   dresp_data;
   memory_data_t  dataM;
   logic          out_valid;
   logic          out_ready;
   state_t        dbg_state;

   memory_stage dut (
      .clk           (clk),
      .resetn        (resetn),
      .dataE         (dataE),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_write    (dreq_write),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data),
      .dataM         (dataM),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dbg_state     (dbg_state)
   );

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   int checks = 0;
   int errors = 0;

   function automatic logic [W-1:0] pack_m(input memory_data_t m);
      logic e;
`ifdef MISALIGN_TRAP_EN
      e = m.exc;
`else
      e = 1'b0;
`endif
      return {e, m.regwrite, m.dst, m.result};
   endfunction

   // ---------------- scoreboard: compare every consumed dataM ----------------
   always @(negedge clk) begin
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h, required no output", pack_m(dataM));
         end else begin
            exp_v = exp_q.pop_front();
            if (pack_m(dataM) !== exp_v) begin
               errors++;
               $display("FAIL sb_dataM: got %h, required %h", pack_m(dataM), exp_v);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic execute_data_t mk(input logic [2:0] f3, input logic rd, input logic wr,
                                        input logic rw, input logic [63:0] res,
                                        input logic [63:0] md, input logic [4:0] dst);
      execute_data_t d;
      d = '0;
      d.pc                = {32'h0, $urandom()};
      d.instruction[14:12] = f3;
      d.instruction[6:0]  = rd ? 7'h03 : (wr ? 7'h23 : 7'h33);
      d.result            = res;
      d.memdata           = md;
      d.ctl.memread       = rd;
      d.ctl.memwrite      = wr;
      d.ctl.regwrite      = rw;
      d.dst               = dst;
      return d;
   endfunction

   task automatic send(input execute_data_t d);
      int n;
      dataE    = d;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_accept: in_ready=%b, required 1", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic respond(input int k, input logic [63:0] raw);
      checks++;
      if (dreq_valid !== 1'b1) begin
         errors++;
         $display("FAIL bus_req: dreq_valid=%b, required 1", dreq_valid);
      end
      for (int i = 1; i < k; i++) step();
      dresp_data    = raw;
      dresp_data_ok = 1'b1;
      step();
      dresp_data_ok = 1'b0;
   endtask

   function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] raw);
      int nb;
      logic [63:0] r;
      logic sgn;
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
      r = '0;
      for (int b = 0; b < 8; b++)
         if (b < nb && int'(off) + b < 8) r[8*b +: 8] = raw[8*(int'(off) + b) +: 8];
      sgn = r[8*nb-1];
      if (!f3[2])
         for (int b = 0; b < 8; b++)
            if (b >= nb) r[8*b +: 8] = {8{sgn}};
      return r;
   endfunction

   // ---------------- test scenarios ----------------
   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      checks++;
      if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rst_dreq_valid: got %b, required 0", dreq_valid); end
      checks++;
      if (dataM !== '0) begin errors++; $display("FAIL rst_dataM: got %h, required 0", dataM); end
      checks++;
      if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d, required IDLE", dbg_state); end
      resetn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_alu();
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 1'b1, 5'd7, 64'h1234});
      send(mk(3'b000, 1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 5'd7));
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_out_valid: got %b, required 1", out_valid); end
      checks++;
      if (dataM.result !== 64'h1234) begin errors++; $display("FAIL alu_result: got %h, required 1234", dataM.result); end
      checks++;
      if (dreq_valid !== 1'b0) begin errors++; $display("FAIL alu_no_bus: dreq_valid=%b, required 0", dreq_valid); end
   endtask

   task automatic test_load_sign();
      exp_q.push_back({1'b0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80});
      send(mk(3'b000, 1'b1, 1'b0, 1'b1, 64'h1003, 64'h0, 5'd5));
      checks++;
      if ({dreq_addr, dreq_write, dreq_size, dreq_strobe} !== {64'h1003, 1'b0, 3'd0, 8'h00}) begin
         errors++;
         $display("FAIL lb_req: got addr=%h wr=%b size=%0d strb=%h, required 1003/0/0/00",
                  dreq_addr, dreq_write, dreq_size, dreq_strobe);
      end
      respond(3, 64'h0000_0000_8000_0000);
      checks++;
      if (out_valid !== 1'b1 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL lb_done: out_valid=%b state=%0d, required 1/IDLE", out_valid, dbg_state);
      end
      exp_q.push_back({1'b0, 1'b1, 5'd6, 64'h80});
      send(mk(3'b100, 1'b1, 1'b0, 1'b1, 64'h1003, 64'h0, 5'd6));
      respond(3, 64'h0000_0000_8000_0000);
   endtask

   task automatic test_store_sh();
      exp_q.push_back({1'b0, 1'b0, 5'd0, 64'h2006});
      send(mk(3'b001, 1'b0, 1'b1, 1'b0, 64'h2006, 64'hBEEF, 5'd0));
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data} !==
             {1'b1, 1'b1, 64'h2006, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000}) begin
            errors++;
            $display("FAIL sh_req_c%0d: got v=%b wr=%b addr=%h size=%0d strb=%h data=%h, required 1/1/2006/1/c0/beef000000000000",
                     c, dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data);
         end
         if (c == 3) dresp_data_ok = 1'b1;
         step();
      end
      dresp_data_ok = 1'b0;
      checks++;
      if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sh_release: dreq_valid=%b, required 0", dreq_valid); end
   endtask

   task automatic test_hold();
      memory_data_t snap;
      logic [63:0] raw;
      raw = {$urandom(), $urandom()};
      exp_q.push_back({1'b0, 1'b1, 5'd9, raw});
      send(mk(3'b011, 1'b1, 1'b0, 1'b1, 64'h3000, 64'h0, 5'd9));
      out_ready = 1'b0;
      respond(2, raw);
      snap = dataM;
      checks++;
      if (out_valid !== 1'b1 || dbg_state !== HOLD) begin
         errors++;
         $display("FAIL hold_enter: out_valid=%b state=%0d, required 1/HOLD", out_valid, dbg_state);
      end
      dataE    = mk(3'b000, 1'b0, 1'b0, 1'b1, 64'h55, 64'h0, 5'd10);
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || dataM !== snap || dbg_state !== HOLD || dreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_c%0d: in_ready=%b state=%0d dreq_valid=%b stable=%b, required 0/HOLD/0/1",
                     c, in_ready, dbg_state, dreq_valid, dataM === snap);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_release_in_ready: got %b, required 0", in_ready); end
      step();
      checks++;
      if (dbg_state !== IDLE || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_exit: state=%0d out_valid=%b, required IDLE/0", dbg_state, out_valid);
      end
      exp_q.push_back({1'b0, 1'b1, 5'd10, 64'h55});
      send(mk(3'b000, 1'b0, 1'b0, 1'b1, 64'h55, 64'h0, 5'd10));
   endtask

   task automatic test_reset_mid_bus();
      send(mk(3'b010, 1'b1, 1'b0, 1'b1, 64'h4000, 64'h0, 5'd11));
      checks++;
      if (dreq_valid !== 1'b1) begin errors++; $display("FAIL mid_bus_req: dreq_valid=%b, required 1", dreq_valid); end
      step();
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (dreq_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL mid_bus_reset: dreq_valid=%b out_valid=%b in_ready=%b state=%0d, required 0/0/0/IDLE",
                  dreq_valid, out_valid, in_ready, dbg_state);
      end
      @(posedge clk);
      #1;
      resetn        = 1'b1;
      dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
      dresp_data_ok = 1'b1;
      step();
      dresp_data_ok = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL stray_data_ok: out_valid=%b state=%0d, required 0/IDLE", out_valid, dbg_state);
      end
      exp_q.push_back({1'b0, 1'b1, 5'd12, 64'hABCD});
      send(mk(3'b000, 1'b0, 1'b0, 1'b1, 64'hABCD, 64'h0, 5'd12));
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL after_reset_alu: out_valid=%b, required 1", out_valid); end
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      exp_q.push_back({1'b1, 1'b0, 5'd3, 64'h1002});
      send(mk(3'b010, 1'b1, 1'b0, 1'b1, 64'h1002, 64'h0, 5'd3));
      checks++;
      if (out_valid !== 1'b1 || dataM.exc !== 1'b1 || dataM.regwrite !== 1'b0 || dreq_valid !== 1'b0) begin
         errors++;
         $display("FAIL misalign_trap: out_valid=%b exc=%b regwrite=%b dreq_valid=%b, required 1/1/0/0",
                  out_valid, dataM.exc, dataM.regwrite, dreq_valid);
      end
`else
      exp_q.push_back({1'b0, 1'b1, 5'd3, 64'hFFFF_FFFF_F333_4444});
      send(mk(3'b010, 1'b1, 1'b0, 1'b1, 64'h1002, 64'h0, 5'd3));
      checks++;
      if (dreq_addr !== 64'h1000 || dreq_size !== 3'd2) begin
         errors++;
         $display("FAIL misalign_addr: got addr=%h size=%0d, required 1000/2", dreq_addr, dreq_size);
      end
      respond(1, 64'h1111_2222_F333_4444);
`endif
   endtask

   task automatic test_back_to_back();
      execute_data_t d;
      logic [63:0] addr, md, raw, exp_dat;
      logic [7:0]  exp_strb;
      logic [2:0]  f3;
      int kind, nb, off;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = mk(3'b000, 1'b0, 1'b0, 1'b1, 64'h100 + 64'(i), 64'h0, 5'(20 + i));
         exp_q.push_back({1'b0, 1'b1, 5'(20 + i), 64'h100 + 64'(i)});
         dataE    = d;
         in_valid = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b, required 1", i, in_ready); end
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            md = {$urandom(), $urandom()};
            exp_q.push_back({1'b0, 1'b1, 5'd1, md});
            send(mk(3'b000, 1'b0, 1'b0, 1'b1, md, 64'h0, 5'd1));
         end else begin
            f3   = (kind == 1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            nb   = 1 << f3[1:0];
            addr = {$urandom(), $urandom()};
            off  = $urandom_range(0, 7) & ~(nb - 1);
            addr[2:0] = 3'(off);
            md   = {$urandom(), $urandom()};
            raw  = {$urandom(), $urandom()};
            if (kind == 1) exp_q.push_back({1'b0, 1'b1, 5'd2, ld_model(f3, 3'(off), raw)});
            else           exp_q.push_back({1'b0, 1'b0, 5'd2, addr});
            send(mk(f3, kind == 1, kind == 2, 1'b1, addr, md, 5'd2));
            if (kind == 2) begin
               exp_strb = '0;
               exp_dat  = '0;
               for (int b = 0; b < 8; b++) begin
                  if (b >= off && b < off + nb) exp_strb[b] = 1'b1;
                  if (b >= off) exp_dat[8*b +: 8] = md[8*(b - off) +: 8];
               end
               checks++;
               if (dreq_strobe !== exp_strb || dreq_data !== exp_dat || dreq_write !== 1'b1) begin
                  errors++;
                  $display("FAIL rnd_store_%0d: got strb=%h data=%h wr=%b, required %h/%h/1",
                           i, dreq_strobe, dreq_data, dreq_write, exp_strb, exp_dat);
               end
            end
            if ($urandom_range(0, 1) == 1) begin
               out_ready = 1'b0;
               respond($urandom_range(1, 3), raw);
               repeat ($urandom_range(0, 2)) step();
               out_ready = 1'b1;
               step();
            end else begin
               respond($urandom_range(1, 3), raw);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      resetn        = 1'b0;
      dataE         = '0;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = '0;
      test_reset();
      test_alu();
      test_load_sign();
      test_store_sh();
      test_hold();
      test_reset_mid_bus();
      test_misalign();
      test_back_to_back();
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
